// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Each iteration does a WIDTH+1-bit trial subtraction on a ripple chain of
// subtractor cells (R + ~D with borrow-in 1); the carry out of the last cell
// is the "no borrow" flag that selects the new partial remainder.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous reset, active-high, overrides all other inputs
//   start        request, sampled only in IDLE
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high during the WIDTH iteration cycles
//   done         one-cycle pulse, results valid
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  divisor was zero, valid with done
//
// Optional feature: define DIVZERO_TRAP_EN to short-circuit a zero divisor
// straight from IDLE to DONE and raise div_by_zero. Without it a zero divisor
// runs the normal iteration and div_by_zero is tied low.

module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   d_inv;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;
    logic             zero_trap;
    logic             unused_diff_msb;

    // Shift {R,Q} left by one and ripple R - {0,D} through the subtractor cells.
    always_comb begin
        r_sh     = {r_reg, q_reg[WIDTH-1]};
        d_inv    = ~{1'b0, d_reg};
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            diff[i]    = r_sh[i] ^ d_inv[i] ^ carry[i];
            carry[i+1] = (r_sh[i] & d_inv[i]) | (carry[i] & (r_sh[i] ^ d_inv[i]));
        end
    end

    // A successful trial leaves diff < D, so its top bit is always zero.
    assign no_borrow       = carry[WIDTH+1];
    assign unused_diff_msb = diff[WIDTH];
    assign r_next          = no_borrow ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_next          = {q_reg[WIDTH-2:0], no_borrow};
    assign last_iter       = (count == CW'(1));

`ifdef DIVZERO_TRAP_EN
    assign zero_trap = (divisor == '0);
`else
    assign zero_trap = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = zero_trap ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg     <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            busy <= (state_next == S_RUN);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        r_reg <= '0;
                        q_reg <= dividend;
                        count <= CW'(WIDTH);
                        if (zero_trap) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                S_RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    count <= count - CW'(1);
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIVZERO_TRAP_EN
    // Flag set by a trapped start, cleared by any other accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (state == S_IDLE && start) begin
            div_by_zero <= zero_trap;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_vec;
    int n_bad;

`ifdef DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic division with the zero-divisor convention.
    function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (b == 0) return '1;
        return a / b;
    endfunction

    function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (b == 0) return a;
        return a % b;
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] b);
        if (TRAP && b == 0) return 1;
        return WIDTH + 1;
    endfunction

    // Present one division at a negedge, scramble operands after acceptance,
    // then check latency, busy length, results, flag and done pulse width.
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        int  n;
        int  bc;
        bit  got;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        logic             ez;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        ez = TRAP && (b == 0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0; bc = 0; got = 1'b0;
        @(negedge clk);
        n = 1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        while (!got && n < 40) begin
            if (busy) bc++;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s timeout: no done after %0d cycles (%0d/%0d)", tag, n, a, b);
            return;
        end
        n_vec++;
        if (n !== ref_lat(b)) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, ref_lat(b));
        end
        n_vec++;
        if (bc !== ref_lat(b) - 1) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, bc, ref_lat(b) - 1);
        end
        n_vec++;
        if (quotient !== eq || remainder !== er) begin
            n_bad++;
            $display("FAIL %s result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                     tag, a, b, quotient, remainder, eq, er);
        end
        n_vec++;
        if (div_by_zero !== ez) begin
            n_bad++;
            $display("FAIL %s div_by_zero: got %b want %b", tag, div_by_zero, ez);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b done=%b dz=%b want 0 0 0", busy, done, div_by_zero);
        end
        n_vec++;
        if (quotient !== '0 || remainder !== '0) begin
            n_bad++;
            $display("FAIL reset_results: got q=%0d r=%0d want 0 0", quotient, remainder);
        end
    endtask

    task automatic test_directed();
        run_div(8'd100, 8'd7, "d100_7");
        run_div(8'd255, 8'd1, "d255_1");
        run_div(8'd5,   8'd9, "d5_9");
        run_div(8'd0,   8'd3, "d0_3");
        run_div(8'd255, 8'd255, "d255_255");
        run_div(8'd254, 8'd255, "d254_255");
    endtask

    task automatic test_div_zero();
        run_div(8'd200, 8'd0, "dz200_0");
        // A following normal division must clear the flag.
        run_div(8'd9, 8'd4, "dz_clear");
    endtask

    // Second request held through RUN and DONE is dropped; results then hold.
    task automatic test_back_to_back();
        int pulses;
        int n;
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd2;
        pulses = 0; n = 0;
        while (pulses == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (done) pulses++;
        end
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_vec++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL b2b_pulses: got %0d want 1", pulses);
        end
        n_vec++;
        if (quotient !== 8'd16 || remainder !== 8'd2) begin
            n_bad++;
            $display("FAIL b2b_result: got q=%0d r=%0d want q=16 r=2", quotient, remainder);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle_busy: got %b want 0", busy);
        end
    endtask

    // Reset on the 4th RUN cycle aborts the division without a done pulse.
    task automatic test_reset_mid_run();
        int runs;
        int pulses;
        start = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        runs = 0; pulses = 0;
        while (runs < 4 && pulses == 0) begin
            if (busy) runs++;
            if (done) pulses++;
            if (runs < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", pulses);
        end
        run_div(8'd77, 8'd5, "midrst_retry");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 4))
                0:       b = WIDTH'($urandom_range(1, 15));
                1:       b = '0;
                2:       b = a;
                default: b = WIDTH'($urandom);
            endcase
            run_div(a, b, "random");
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
